// File: rtl/vending_machine_multi_if.sv
// Request/response bundle of the coin-change vending controller.
// The tester side drives coins and item selection; the controller side returns change, item and status.
interface vending_machine_multi_if #(
  parameter int unsigned IN_W  = 2,
  parameter int unsigned CNT_W = 3
);
  logic [IN_W-1:0]  coinInNTD_5;
  logic [IN_W-1:0]  coinInNTD_1;
  logic [1:0]       itemTypeIn;
  logic [CNT_W-1:0] coinOutNTD_5;
  logic [CNT_W-1:0] coinOutNTD_1;
  logic [1:0]       itemTypeOut;
  logic [1:0]       serviceTypeOut;
  logic             p1;
  logic             p2;
  logic             p3;

  modport master (
    output coinInNTD_5, coinInNTD_1, itemTypeIn,
    input  coinOutNTD_5, coinOutNTD_1, itemTypeOut, serviceTypeOut, p1, p2, p3
  );

  modport slave (
    input  coinInNTD_5, coinInNTD_1, itemTypeIn,
    output coinOutNTD_5, coinOutNTD_1, itemTypeOut, serviceTypeOut, p1, p2, p3
  );
endinterface

// File: rtl/vending_machine_multi.sv
// Three-item coin-change vending controller with greedy change (5s then 1s) and full refund fallback.
// Optional per-item stock tracking is enabled with the VEND_STOCK_EN macro.
module vending_machine_multi #(
  parameter int unsigned CNT_W  = 3,
  parameter int unsigned IN_W   = 2,
  parameter int unsigned VAL_W  = 6,
  parameter int unsigned INIT_5 = 2,
  parameter int unsigned INIT_1 = 2,
  parameter int unsigned COST_A = 6,
  parameter int unsigned COST_B = 8,
  parameter int unsigned COST_C = 12
`ifdef VEND_STOCK_EN
  ,
  parameter int unsigned STOCK_INIT = 3
`endif
) (
  input  logic                   clk,
  input  logic                   reset,
  vending_machine_multi_if.slave bus
);

  typedef enum logic [1:0] {
    SVC_OFF  = 2'b00,
    SVC_ON   = 2'b01,
    SVC_BUSY = 2'b10
  } svc_t;

  typedef enum logic [1:0] {
    PH_CHECK = 2'b00,
    PH_CHG5  = 2'b01,
    PH_CHG1  = 2'b10
  } phase_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  svc_t             svc;
  phase_t           phase;
  logic [CNT_W-1:0] out5;
  logic [CNT_W-1:0] out1;
  logic [CNT_W-1:0] vault5;
  logic [CNT_W-1:0] vault1;
  logic [1:0]       item;
  logic [VAL_W-1:0] in_val;
  logic [VAL_W-1:0] svc_val;
  logic             refund;
  logic             initialized;

  logic [VAL_W-1:0] cost_c;
  logic [VAL_W-1:0] coin_val_c;
  logic [VAL_W-1:0] req_val_c;
  logic             short_c;
  logic             p1_c;
  logic             p2_c;
  logic             p3_c;

`ifdef VEND_STOCK_EN
  logic [3:0][CNT_W-1:0] stock;
  logic                  off_entry_c;
`endif

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? CNT_MAX : s[CNT_W-1:0];
  endfunction

  function automatic logic [VAL_W-1:0] cost_of(input logic [1:0] it);
    logic [VAL_W-1:0] c;
    case (it)
      2'd1:    c = VAL_W'(COST_A);
      2'd2:    c = VAL_W'(COST_B);
      2'd3:    c = VAL_W'(COST_C);
      default: c = '0;
    endcase
    return c;
  endfunction

  // Pricing, coin values and model-checking properties
  always_comb begin
    cost_c     = cost_of(item);
    coin_val_c = VAL_W'(out5) * VAL_W'(5) + VAL_W'(out1);
    req_val_c  = VAL_W'(bus.coinInNTD_5) * VAL_W'(5) + VAL_W'(bus.coinInNTD_1);
    short_c    = in_val < cost_c;
`ifdef VEND_STOCK_EN
    // An empty slot is treated exactly like insufficient money
    if (stock[item] == '0) short_c = 1'b1;
    off_entry_c = (svc == SVC_BUSY) && (phase == PH_CHG1) &&
                  ((svc_val == '0) || ((vault1 == '0) && refund));
`endif
    p1_c = initialized && (svc == SVC_OFF) && (item == 2'd0) && (coin_val_c != in_val);
    p2_c = initialized && (svc == SVC_ON) && ((out5 != '0) || (out1 != '0));
    p3_c = initialized && (svc == SVC_OFF) && (item != 2'd0) &&
           ((cost_c + coin_val_c) != in_val);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      svc         <= SVC_ON;
      phase       <= PH_CHECK;
      out5        <= '0;
      out1        <= '0;
      item        <= 2'd0;
      vault5      <= CNT_W'(INIT_5);
      vault1      <= CNT_W'(INIT_1);
      in_val      <= '0;
      svc_val     <= '0;
      refund      <= 1'b0;
      initialized <= 1'b1;
    end else begin
      case (svc)
        SVC_ON: begin
          if (bus.itemTypeIn != 2'd0) begin
            in_val <= req_val_c;
            vault5 <= sat_add(vault5, CNT_W'(bus.coinInNTD_5));
            vault1 <= sat_add(vault1, CNT_W'(bus.coinInNTD_1));
            out5   <= '0;
            out1   <= '0;
            item   <= bus.itemTypeIn;
            svc    <= SVC_BUSY;
            phase  <= PH_CHECK;
          end
        end
        SVC_BUSY: begin
          case (phase)
            PH_CHECK: begin
              if (short_c) begin
                item    <= 2'd0;
                refund  <= 1'b1;
                svc_val <= in_val;
              end else begin
                svc_val <= in_val - cost_c;
              end
              phase <= PH_CHG5;
            end
            PH_CHG5: begin
              if ((svc_val >= VAL_W'(5)) && (vault5 != '0)) begin
                out5    <= sat_add(out5, CNT_W'(1));
                vault5  <= vault5 - CNT_W'(1);
                svc_val <= svc_val - VAL_W'(5);
              end else begin
                phase <= PH_CHG1;
              end
            end
            PH_CHG1: begin
              if (svc_val == '0) begin
                svc <= SVC_OFF;
              end else if (vault1 != '0) begin
                out1    <= sat_add(out1, CNT_W'(1));
                vault1  <= vault1 - CNT_W'(1);
                svc_val <= svc_val - VAL_W'(1);
              end else if (!refund) begin
                // Change impossible: put dispensed coins back and refund everything
                vault5  <= sat_add(vault5, out5);
                vault1  <= sat_add(vault1, out1);
                out5    <= '0;
                out1    <= '0;
                item    <= 2'd0;
                svc_val <= in_val;
                refund  <= 1'b1;
                phase   <= PH_CHG5;
              end else begin
                svc <= SVC_OFF;
              end
            end
            default: phase <= PH_CHECK;
          endcase
        end
        SVC_OFF: begin
          out5   <= '0;
          out1   <= '0;
          item   <= 2'd0;
          refund <= 1'b0;
          svc    <= SVC_ON;
        end
        default: svc <= SVC_ON;
      endcase
    end
  end

`ifdef VEND_STOCK_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      stock <= {4{CNT_W'(STOCK_INIT)}};
    end else if (off_entry_c && (item != 2'd0)) begin
      stock[item] <= stock[item] - CNT_W'(1);
    end
  end
`endif

  assign bus.coinOutNTD_5   = out5;
  assign bus.coinOutNTD_1   = out1;
  assign bus.itemTypeOut    = item;
  assign bus.serviceTypeOut = svc;
  assign bus.p1             = p1_c;
  assign bus.p2             = p2_c;
  assign bus.p3             = p3_c;

endmodule

// File: tb/tb_vending_machine_multi.sv
// Scoreboard bench for vending_machine_multi: each sale pushes its expected result,
// a negedge monitor pops and compares when the controller reports OFF.
module tb_vending_machine_multi;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  vending_machine_multi_if bus ();

`ifdef VEND_STOCK_EN
  vending_machine_multi #(.STOCK_INIT(1)) dut (.clk(clk), .reset(reset), .bus(bus));
`else
  vending_machine_multi dut (.clk(clk), .reset(reset), .bus(bus));
`endif

  typedef struct {
    int    o5;
    int    o1;
    int    it;
    int    lat;
    int    start;
    string name;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: p2 must stay low while idle; OFF cycles are matched against the scoreboard
  always @(negedge clk) begin : mon
    exp_t e;
    if (reset) begin
      if (bus.serviceTypeOut == 2'b01) check("p2_idle", 32'(bus.p2), 0);
      if (bus.serviceTypeOut == 2'b00) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_off: got OFF at cycle %0d expected no result", cyc);
        end else begin
          e = sb.pop_front();
          check({e.name, "_out5"}, 32'(bus.coinOutNTD_5), 32'(e.o5));
          check({e.name, "_out1"}, 32'(bus.coinOutNTD_1), 32'(e.o1));
          check({e.name, "_item"}, 32'(bus.itemTypeOut), 32'(e.it));
          check({e.name, "_lat"}, 32'(cyc - e.start), 32'(e.lat));
          check({e.name, "_p1"}, 32'(bus.p1), 0);
          check({e.name, "_p3"}, 32'(bus.p3), 0);
        end
      end
    end
  end

  task automatic clear_inputs();
    bus.coinInNTD_5 = '0;
    bus.coinInNTD_1 = '0;
    bus.itemTypeIn  = '0;
  endtask

  task automatic do_reset(input string nm);
    reset = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check({nm, "_svc"}, 32'(bus.serviceTypeOut), 1);
    check({nm, "_out5"}, 32'(bus.coinOutNTD_5), 0);
    check({nm, "_out1"}, 32'(bus.coinOutNTD_1), 0);
    check({nm, "_item"}, 32'(bus.itemTypeOut), 0);
    check({nm, "_p"}, 32'({bus.p1, bus.p2, bus.p3}), 0);
    reset = 1'b1;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (!(sb.size() == 0 && bus.serviceTypeOut == 2'b01) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got svc=%0d pending=%0d expected idle", nm,
               bus.serviceTypeOut, sb.size());
      sb.delete();
    end
  endtask

  task automatic sell(input int c5, input int c1, input int it, input string nm,
                      input int o5, input int o1, input int eit, input int lat);
    exp_t e;
    @(posedge clk);
    #1;
    e.o5 = o5; e.o1 = o1; e.it = eit; e.lat = lat; e.start = cyc; e.name = nm;
    sb.push_back(e);
    bus.coinInNTD_5 = 2'(c5);
    bus.coinInNTD_1 = 2'(c1);
    bus.itemTypeIn  = 2'(it);
    @(posedge clk);
    #1;
    clear_inputs();
    wait_idle(nm);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_inputs();

    // Sale with one coin of change
    do_reset("rst1");
    sell(1, 2, 1, "t1_a_chg1", 0, 1, 1, 5);

    // Not enough money: full refund, then vaults must be back to 2/2
    do_reset("rst2");
    sell(2, 0, 3, "t2_c_short", 2, 0, 0, 6);
    sell(3, 0, 1, "t2_vault_probe", 3, 0, 0, 12);

    // Idle with coins but no item: nothing accepted
    do_reset("rst4");
    bus.coinInNTD_5 = 2'd3;
    bus.coinInNTD_1 = 2'd3;
    bus.itemTypeIn  = 2'd0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_svc", 32'(bus.serviceTypeOut), 1);
      check("t4_outs", 32'({bus.coinOutNTD_5, bus.coinOutNTD_1, bus.itemTypeOut}), 0);
    end
    clear_inputs();
    // Change 9 with only two 1s in the vault: abort and refund three 5s
    sell(3, 0, 1, "t3_abort_refund", 3, 0, 0, 12);

    // Reset in the middle of change-giving
    do_reset("rst5");
    @(posedge clk);
    #1;
    bus.coinInNTD_5 = 2'd1;
    bus.coinInNTD_1 = 2'd2;
    bus.itemTypeIn  = 2'd1;
    @(posedge clk);
    #1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("t5_svc", 32'(bus.serviceTypeOut), 1);
    check("t5_out5", 32'(bus.coinOutNTD_5), 0);
    check("t5_out1", 32'(bus.coinOutNTD_1), 0);
    check("t5_item", 32'(bus.itemTypeOut), 0);
    check("t5_p2", 32'(bus.p2), 0);
    reset = 1'b1;
    sell(3, 0, 1, "t5_vault_probe", 3, 0, 0, 12);

    // Exact-change sales at the minimum latency
    sell(1, 3, 2, "t7_b_exact", 0, 0, 2, 4);
    do_reset("rst8");
    sell(2, 2, 3, "t8_c_exact", 0, 0, 3, 4);

`ifdef VEND_STOCK_EN
    // One unit per item: the second purchase of A is refunded
    do_reset("rst6");
    sell(1, 3, 2, "t6_b_load", 0, 0, 2, 4);
    sell(2, 0, 1, "t6_a_first", 0, 4, 1, 8);
    sell(2, 0, 1, "t6_a_sold_out", 2, 0, 0, 6);
`endif

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
